// File: rtl/gfa_komut_yurutucu_if.sv
// ---------------------------------------------------------------------------
// gfa_komut_yurutucu_if
//   Command and result channels of the command executor.
//
//   komut channel : komut_gecerli/komut toward the executor, komut_hazir back.
//   veri channel  : veri/veri_gecerli from the executor, veri_hazir back.
//
//   Modports:
//     master : the side that sends commands and accepts results (bridge / bench)
//     slave  : the command executor itself
// ---------------------------------------------------------------------------
interface gfa_komut_yurutucu_if #(
  parameter int VERI_BIT = 32
);
  logic                komut_gecerli;
  logic [VERI_BIT-1:0] komut;
  logic                komut_hazir;
  logic [VERI_BIT-1:0] veri;
  logic                veri_gecerli;
  logic                veri_hazir;

  modport master (
    output komut_gecerli,
    output komut,
    input  komut_hazir,
    input  veri,
    input  veri_gecerli,
    output veri_hazir
  );

  modport slave (
    input  komut_gecerli,
    input  komut,
    output komut_hazir,
    output veri,
    output veri_gecerli,
    input  veri_hazir
  );
endinterface

// File: rtl/gfa_komut_yurutucu.sv
// ---------------------------------------------------------------------------
// gfa_komut_yurutucu
//   Command executor behind the AXI4-Lite to FIFO bridge. Command words are
//   buffered in a small FIFO and executed against a local register file:
//     0x0 NOP, 0x1 YAZ (write, data in the next word), 0x2 OKU (read),
//     0x3 OKU_SERI (burst read of [15:8]+1 words, address wraps),
//     0x4 DURUM (status word). Opcodes 0x5-0xF are dropped as invalid.
//
//   Ports:
//     ACLK     : clock, rising edge
//     ARESETn  : asynchronous active-low reset
//     bus      : slave modport of gfa_komut_yurutucu_if (komut / veri channels)
//     hata     : registered OR of the sticky tasma / gecersiz flags
//
//   Opcode sits in [31:28]; VERI_BIT is expected to be 32.
// ---------------------------------------------------------------------------
module gfa_komut_yurutucu #(
  parameter int VERI_BIT      = 32,
  parameter int FIFO_DERINLIK = 4,
  parameter int REG_SAYISI    = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  gfa_komut_yurutucu_if.slave   bus,
  output logic                  hata
);

  localparam int FAW = $clog2(FIFO_DERINLIK);
  localparam int CW  = FAW + 1;
  localparam int AW  = $clog2(REG_SAYISI);

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_YAZ      = 4'h1;
  localparam logic [3:0] OP_OKU      = 4'h2;
  localparam logic [3:0] OP_OKU_SERI = 4'h3;
  localparam logic [3:0] OP_DURUM    = 4'h4;

  typedef enum logic [1:0] {
    BOSTA      = 2'd0,
    VERI_BEKLE = 2'd1,
    GONDER     = 2'd2
  } durum_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [VERI_BIT-1:0] fifo_mem [FIFO_DERINLIK];
  logic [FAW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;

  logic [VERI_BIT-1:0] reg_q [REG_SAYISI];

  durum_e              state_q;
  logic [AW-1:0]       addr_q;
  logic [7:0]          kalan_q;      // words still to send after the current one
  logic                durum_q;      // current result word is a status word
  logic [VERI_BIT-1:0] veri_q;
  logic                veri_gecerli_q;
  logic                tasma_q, gecersiz_q, hata_q;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic                fifo_full, fifo_empty;
  logic                push, pop;
  logic [VERI_BIT-1:0] head;
  logic [3:0]          opkod;
  logic [AW-1:0]       head_addr, addr_nxt;
  logic                handshake;
  logic                durum_kabul;
  logic                tasma_d, gecersiz_d;
  logic [VERI_BIT-1:0] durum_word;

  assign fifo_full  = (count_q == CW'(FIFO_DERINLIK));
  assign fifo_empty = (count_q == '0);

  // A word offered while full is simply lost (and flagged below).
  assign push = bus.komut_gecerli && !fifo_full;
  // The FSM only consumes FIFO words while idle or waiting for write data.
  assign pop  = !fifo_empty && ((state_q == BOSTA) || (state_q == VERI_BEKLE));

  assign head      = fifo_mem[rd_ptr_q];
  assign opkod     = head[31:28];
  assign head_addr = head[AW-1:0];
  assign addr_nxt  = addr_q + AW'(1);   // natural wrap modulo REG_SAYISI

  assign handshake = veri_gecerli_q && bus.veri_hazir;

  // komut_hazir is held low during reset and whenever a word is being offered.
  assign bus.komut_hazir  = ARESETn && !fifo_full && !bus.komut_gecerli;
  assign bus.veri         = veri_q;
  assign bus.veri_gecerli = veri_gecerli_q;
  assign hata             = hata_q;

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    durum_word                 = '0;
    durum_word[VERI_BIT-1]     = tasma_q;
    durum_word[VERI_BIT-2]     = gecersiz_q;
    durum_word[7:0]            = 8'(count_q);   // occupancy including the DURUM word itself

    // Status flags clear when the status word is accepted; a new set event in
    // that same cycle takes priority over the clear.
    durum_kabul = (state_q == GONDER) && durum_q && handshake;
    tasma_d     = (bus.komut_gecerli && fifo_full) || (tasma_q && !durum_kabul);
    gecersiz_d  = ((state_q == BOSTA) && pop && (opkod > OP_DURUM)) ||
                  (gecersiz_q && !durum_kabul);
  end

  // -------------------------------------------------------------------------
  // FIFO storage
  // NOTE: the FIFO array has no reset; its contents are only ever read
  // through the pointers/count, which are reset, so stale words are unreachable.
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.komut;
  end

  // -------------------------------------------------------------------------
  // FIFO control, flags, register file and executor FSM
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= BOSTA;
      addr_q         <= '0;
      kalan_q        <= '0;
      durum_q        <= 1'b0;
      veri_q         <= '0;
      veri_gecerli_q <= 1'b0;
      tasma_q        <= 1'b0;
      gecersiz_q     <= 1'b0;
      hata_q         <= 1'b0;
      // The register file is architecturally visible and must read as zero
      // after reset, so it is reset explicitly (small enough for flops).
      for (int i = 0; i < REG_SAYISI; i++) reg_q[i] <= '0;
    end else begin
      // FIFO bookkeeping; simultaneous push and pop leaves count unchanged.
      if (push) wr_ptr_q <= wr_ptr_q + FAW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FAW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      tasma_q    <= tasma_d;
      gecersiz_q <= gecersiz_d;
      hata_q     <= tasma_d || gecersiz_d;

      case (state_q)
        BOSTA: begin
          if (pop) begin
            case (opkod)
              OP_YAZ: begin
                addr_q  <= head_addr;
                state_q <= VERI_BEKLE;
              end
              OP_OKU, OP_OKU_SERI: begin
                addr_q         <= head_addr;
                kalan_q        <= (opkod == OP_OKU_SERI) ? head[15:8] : 8'd0;
                durum_q        <= 1'b0;
                veri_q         <= reg_q[head_addr];
                veri_gecerli_q <= 1'b1;
                state_q        <= GONDER;
              end
              OP_DURUM: begin
                kalan_q        <= 8'd0;
                durum_q        <= 1'b1;
                veri_q         <= durum_word;
                veri_gecerli_q <= 1'b1;
                state_q        <= GONDER;
              end
              default: ;   // NOP and invalid opcodes are consumed without effect
            endcase
          end
        end

        VERI_BEKLE: begin
          // The data word is written as-is, never decoded as an opcode.
          if (pop) begin
            reg_q[addr_q] <= head;
            state_q       <= BOSTA;
          end
        end

        GONDER: begin
          if (handshake) begin
            if (kalan_q != 8'd0) begin
              addr_q  <= addr_nxt;
              kalan_q <= kalan_q - 8'd1;
              veri_q  <= reg_q[addr_nxt];
            end else begin
              veri_gecerli_q <= 1'b0;
              durum_q        <= 1'b0;
              state_q        <= BOSTA;
            end
          end
        end

        default: state_q <= BOSTA;
      endcase
    end
  end

endmodule

// File: tb/tb_gfa_komut_yurutucu.sv
// ---------------------------------------------------------------------------
// tb_gfa_komut_yurutucu
//   Directed bench for gfa_komut_yurutucu (VERI_BIT=32, FIFO_DERINLIK=4,
//   REG_SAYISI=16). Inputs change 1 time unit after the rising edge; accepted
//   result words are collected into a queue on the falling edge.
// ---------------------------------------------------------------------------
module tb_gfa_komut_yurutucu;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic hata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rx [$];

  gfa_komut_yurutucu_if #(.VERI_BIT(32)) bus ();

  gfa_komut_yurutucu #(
    .VERI_BIT      (32),
    .FIFO_DERINLIK (4),
    .REG_SAYISI    (16)
  ) dut (
    .ACLK    (clk),
    .ARESETn (rst_n),
    .bus     (bus),
    .hata    (hata)
  );

  always #5 clk = ~clk;

  // Capture every accepted result word.
  always @(negedge clk) begin
    if (bus.veri_gecerli && bus.veri_hazir) rx.push_back(bus.veri);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rx_at(input int i);
    if (i < rx.size()) return rx[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    bus.komut_gecerli = 1'b1;
    bus.komut         = w;
    tick();
    bus.komut_gecerli = 1'b0;
    bus.komut         = '0;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
    push({24'h100000, a});
    push(d);
  endtask

  initial begin
    bus.komut_gecerli = 1'b0;
    bus.komut         = '0;
    bus.veri_hazir    = 1'b0;

    // ---------------- reset state ----------------
    #12;
    check("rst_komut_hazir",  32'(bus.komut_hazir),  32'd0);
    check("rst_veri_gecerli", 32'(bus.veri_gecerli), 32'd0);
    check("rst_veri",         bus.veri,              32'd0);
    check("rst_hata",         32'(hata),             32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel_komut_hazir",  32'(bus.komut_hazir),  32'd1);
    check("rel_veri_gecerli", 32'(bus.veri_gecerli), 32'd0);
    check("rel_hata",         32'(hata),             32'd0);

    // ---------------- write then read ----------------
    bus.veri_hazir = 1'b1;
    rx.delete();
    bus.komut_gecerli = 1'b1;
    bus.komut         = 32'h1000_0005;
    #1;
    check("hazir_low_while_offer", 32'(bus.komut_hazir), 32'd0);
    tick();
    push(32'hDEAD_BEEF);
    push(32'h2000_0005);
    repeat (4) tick();
    check("wr_rd_count", 32'(rx.size()), 32'd1);
    check("wr_rd_data",  rx_at(0),       32'hDEAD_BEEF);

    // ---------------- burst with wrap ----------------
    write_reg(8'd14, 32'h0000_000A);
    write_reg(8'd15, 32'h0000_000B);
    write_reg(8'd0,  32'h0000_000C);
    repeat (3) tick();
    bus.veri_hazir = 1'b0;
    rx.delete();
    push(32'h3000_020E);
    tick();                                    // popped, first word presented
    check("burst_vg0",  32'(bus.veri_gecerli), 32'd1);
    check("burst_w0",   bus.veri,              32'h0000_000A);
    bus.veri_hazir = 1'b1; tick();
    check("burst_w1",   bus.veri,              32'h0000_000B);
    bus.veri_hazir = 1'b0; tick();
    check("burst_stall_vg",   32'(bus.veri_gecerli), 32'd1);
    check("burst_stall_data", bus.veri,              32'h0000_000B);
    bus.veri_hazir = 1'b1; tick();
    check("burst_w2",   bus.veri,              32'h0000_000C);
    tick();
    check("burst_done_vg", 32'(bus.veri_gecerli), 32'd0);
    check("burst_count",   32'(rx.size()),        32'd3);
    check("burst_rx0",     rx_at(0),              32'h0000_000A);
    check("burst_rx1",     rx_at(1),              32'h0000_000B);
    check("burst_rx2",     rx_at(2),              32'h0000_000C);

    // ---------------- overflow ----------------
    bus.veri_hazir = 1'b0;
    rx.delete();
    push(32'h2000_0005);
    repeat (6) push(32'h0000_0000);             // 4 fit, 2 are dropped
    check("ovf_full_hazir", 32'(bus.komut_hazir), 32'd0);
    check("ovf_hata",       32'(hata),            32'd1);
    bus.veri_hazir = 1'b1;
    repeat (6) tick();
    check("ovf_rd_count", 32'(rx.size()), 32'd1);
    check("ovf_rd_data",  rx_at(0),       32'hDEAD_BEEF);
    rx.delete();
    push(32'h4000_0000);
    repeat (4) tick();
    check("ovf_durum",       rx_at(0),   32'h8000_0001);
    check("ovf_hata_clear",  32'(hata),  32'd0);

    // ---------------- illegal opcode ----------------
    rx.delete();
    push(32'h7000_0000);
    repeat (3) tick();
    check("ill_no_output", 32'(rx.size()),        32'd0);
    check("ill_vg",        32'(bus.veri_gecerli), 32'd0);
    check("ill_hata",      32'(hata),             32'd1);
    push(32'h4000_0000);
    repeat (4) tick();
    check("ill_durum",      rx_at(0),  32'h4000_0001);
    check("ill_hata_clear", 32'(hata), 32'd0);

    // ---------------- async reset mid-burst ----------------
    bus.veri_hazir = 1'b0;
    rx.delete();
    push(32'h3000_0700);                       // 8 words from reg 0
    push(32'h0000_0000);
    push(32'h0000_0000);
    check("arst_pre_vg",   32'(bus.veri_gecerli), 32'd1);
    check("arst_pre_data", bus.veri,              32'h0000_000C);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_vg_drop",  32'(bus.veri_gecerli), 32'd0);
    check("arst_veri",     bus.veri,              32'd0);
    check("arst_hazir",    32'(bus.komut_hazir),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_rel_hazir", 32'(bus.komut_hazir), 32'd1);
    bus.veri_hazir = 1'b1;
    rx.delete();
    push(32'h4000_0000);                       // FIFO must be empty: count 1
    push(32'h2000_000E);                       // register file back to zero
    repeat (5) tick();
    check("arst_rx_count", 32'(rx.size()), 32'd2);
    check("arst_durum",    rx_at(0),       32'h0000_0001);
    check("arst_oku",      rx_at(1),       32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gfa_komut_yurutucu.md
Name: gfa_komut_yurutucu

Overview:
- Downstream consumer of the AXI4-Lite to general-FIFO bridge.
- Accepts 32-bit command words on the komut channel and buffers them in a small FIFO.
- Executes each command against a local register file: write, single read, burst read, or status.
- Returns read results on the veri channel, which feeds the bridge's read path.

Parameters:
VERI_BIT, 32, command/data word width
FIFO_DERINLIK, 4, command FIFO depth (power of two, >=2)
REG_SAYISI, 16, register file entries (power of two, <=256); address = low log2(REG_SAYISI) bits of field

Ports:
ACLK  input  1  clock, all logic on rising edge
ARESETn  input  1  asynchronous active-low reset
komut_gecerli  input  1  command word present this cycle
komut  input  VERI_BIT  command word
komut_hazir  output  1  block can take a word in the next cycle
veri  output  VERI_BIT  result word
veri_gecerli  output  1  result word valid
veri_hazir  input  1  downstream accepts result word
hata  output  1  OR of sticky error flags

Behaviour:
- Reset (async, ARESETn=0): FIFO empty; FSM in BOSTA; all registers and flags 0. Outputs held at komut_hazir=0, veri_gecerli=0, veri=0, hata=0. Reset mid-burst or mid-write abandons the operation with no partial register write.
- Clock and reset: single clock ACLK; reset ARESETn is asynchronous and active-low.
- Command channel: any cycle with komut_gecerli=1 pushes komut. komut_gecerli is not qualified by komut_hazir.
  - komut_hazir = (count < FIFO_DERINLIK) && !komut_gecerli, registered-free combinational.
  - Push while full: word dropped, flag tasma set.
  - Push and pop in the same cycle are both allowed; count is unchanged.
- Command format, opcode in [31:28]:
  - 0x0 NOP: consumed, no effect.
  - 0x1 YAZ: address in [7:0]; the next FIFO word is the data. reg[addr] is written when that data word is popped.
  - 0x2 OKU: one result word = reg[addr].
  - 0x3 OKU_SERI: produces [15:8]+1 words (1..256) from reg[addr], reg[addr+1], and so on. Address wraps modulo REG_SAYISI.
  - 0x4 DURUM: one word = {tasma, gecersiz, 22'b0, count[7:0] at pop}. Both flags clear on acceptance of that word; a flag set in the same cycle wins.
  - 0x5-0xF: dropped, flag gecersiz set.
- FSM:
  - BOSTA: pops when FIFO non-empty. YAZ goes to VERI_BEKLE. OKU/OKU_SERI/DURUM go to GONDER. Others stay in BOSTA.
  - VERI_BEKLE: waits for non-empty, pops the data word, writes reg, returns to BOSTA. The data word is never decoded as an opcode.
  - GONDER: veri_gecerli=1, veri stable until veri_gecerli && veri_hazir.
    - On handshake with remaining>0: next word presented the following cycle, address+1, remaining-1.
    - On the last handshake: return to BOSTA.
    - Sustained veri_hazir=1 gives one word per cycle.
- Latency:
  - Pop at cycle t gives veri_gecerli at t+1.
  - A word pushed into an empty FIFO in BOSTA is popped the next cycle.
  - A write is visible to an OKU popped one cycle after the data-word pop.
- Registers: read-after-write through the register file only; no bypass of FIFO words.
- hata = tasma | gecersiz, registered.

Test Plan:
- Reset release: komut_hazir=1 the cycle after ARESETn rises; veri_gecerli=0, hata=0.
- Write then read: push 0x10000005, 0xDEADBEEF, 0x20000005 with veri_hazir=1 -> one word veri=0xDEADBEEF; reg 5 unaffected by prior reset value.
- Burst with wrap: REG_SAYISI=16, regs 14/15/0 preloaded 0xA/0xB/0xC; push 0x3000020E; veri_hazir toggled 1,0,1,1 -> words 0xA,0xB,0xC in order; veri held stable during the stall; 3 handshakes total.
- Overflow: hold veri_hazir=0, push an OKU, then force 6 extra komut_gecerli pulses -> words beyond FIFO_DERINLIK dropped; hata=1. A later DURUM returns bit31=1; after acceptance, hata=0.
- Illegal opcode: push 0x70000000 -> no veri output; gecersiz=1. DURUM returns bit30=1 and count field correct.
- Async reset mid-burst: assert ARESETn=0 asynchronously during OKU_SERI of 8 -> veri_gecerli falls immediately without waiting for a clock edge. After release, FIFO is empty and a fresh OKU works.
